// File: rtl/sha256_round_controller.sv
// rtl/sha256_round_controller.sv - SHA-256 block sequencing FSM (init, 64 rounds, hash update, digest handshake)
module sha256_round_controller #(
    parameter int NUM_ROUNDS = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       blk_valid,
    output logic       blk_ready,
    input  logic       first_blk,
    input  logic       last_blk,
    input  logic       abort,
    output logic       init_iv,
    output logic       load_vars,
    output logic       round_en,
    output logic [5:0] k_addr,
    output logic       w_sched,
    output logic       h_update,
    output logic       digest_valid,
    input  logic       digest_ready,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_ROUND,
        S_UPDATE,
        S_DONE
    } state_t;

    localparam logic [6:0] LAST_RND = 7'(NUM_ROUNDS - 1);

    state_t     state_q, state_d;
    logic [6:0] cnt_q, cnt_d;
    logic       first_q, first_d;
    logic       last_q, last_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 7'd0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            first_q <= first_d;
            last_q  <= last_d;
        end
    end

    assign blk_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        first_d      = first_q;
        last_d       = last_q;
        init_iv      = 1'b0;
        load_vars    = 1'b0;
        round_en     = 1'b0;
        k_addr       = 6'd0;
        w_sched      = 1'b0;
        h_update     = 1'b0;
        digest_valid = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (blk_valid) begin
                    state_d = S_INIT;
                    cnt_d   = 7'd0;
                    first_d = first_blk;
                    last_d  = last_blk;
                end
            end
            S_INIT: begin
                init_iv   = first_q;
                load_vars = ~first_q;
                cnt_d     = 7'd0;
                state_d   = S_ROUND;
            end
            S_ROUND: begin
                round_en = 1'b1;
                k_addr   = cnt_q[5:0];
                w_sched  = (cnt_q >= 7'd16);
                // Counter parks on the final round index rather than running past it.
                if (cnt_q == LAST_RND) begin
                    state_d = S_UPDATE;
                end else begin
                    cnt_d = cnt_q + 7'd1;
                end
            end
            S_UPDATE: begin
                h_update = 1'b1;
                state_d  = last_q ? S_DONE : S_IDLE;
            end
            S_DONE: begin
                digest_valid = 1'b1;
                if (digest_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort overrides every transition, including an accept in IDLE.
        if (abort) begin
            state_d = S_IDLE;
            cnt_d   = 7'd0;
            first_d = first_q;
            last_d  = last_q;
        end
    end

endmodule

// File: tb/tb_sha256_round_controller.sv
// tb/tb_sha256_round_controller.sv - randomized self-checking bench with a cycle-offset reference model
module tb_sha256_round_controller;

    localparam int N = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       blk_valid = 1'b0;
    logic       first_blk = 1'b0;
    logic       last_blk = 1'b0;
    logic       abort = 1'b0;
    logic       digest_ready = 1'b0;
    logic       blk_ready, init_iv, load_vars, round_en, w_sched, h_update, digest_valid, busy;
    logic [5:0] k_addr;

    int checks = 0;
    int errors = 0;

    sha256_round_controller #(.NUM_ROUNDS(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .blk_valid    (blk_valid),
        .blk_ready    (blk_ready),
        .first_blk    (first_blk),
        .last_blk     (last_blk),
        .abort        (abort),
        .init_iv      (init_iv),
        .load_vars    (load_vars),
        .round_en     (round_en),
        .k_addr       (k_addr),
        .w_sched      (w_sched),
        .h_update     (h_update),
        .digest_valid (digest_valid),
        .digest_ready (digest_ready),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Reference: a block is "m_off" cycles past its accept edge; 1 = init, 2..N+1 = rounds, N+2 = update.
    bit m_act, m_done, m_first, m_last;
    int m_off;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_act <= 0; m_done <= 0; m_off <= 0; m_first <= 0; m_last <= 0;
        end else if (abort) begin
            m_act <= 0; m_done <= 0; m_off <= 0;
        end else if (m_done) begin
            if (digest_ready) m_done <= 0;
        end else if (m_act) begin
            if (m_off == N + 2) begin
                m_act  <= 0;
                m_done <= m_last;
            end else begin
                m_off <= m_off + 1;
            end
        end else if (blk_valid) begin
            m_act <= 1; m_off <= 1; m_first <= first_blk; m_last <= last_blk;
        end
    end

    task automatic tick();
        logic [13:0] exp_v, act_v;
        bit          e_rnd;
        @(posedge clk);
        @(negedge clk);
        e_rnd = m_act && (m_off >= 2) && (m_off <= N + 1);
        exp_v = {!(m_act || m_done), (m_act || m_done),
                 m_act && (m_off == 1) && m_first, m_act && (m_off == 1) && !m_first,
                 e_rnd, e_rnd ? 6'(m_off - 2) : 6'd0, e_rnd && (m_off - 2 >= 16),
                 m_act && (m_off == N + 2), m_done};
        act_v = {blk_ready, busy, init_iv, load_vars, round_en, k_addr, w_sched, h_update, digest_valid};
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL model_outputs t=%0t got %h want %h", $time, act_v, exp_v);
        end
        checks++;
        if ((32'(init_iv) + 32'(load_vars) + 32'(h_update) + 32'(round_en)) > 1) begin
            errors++;
            $display("FAIL exclusive t=%0t got %b%b%b%b want at most one", $time, init_iv, load_vars, h_update, round_en);
        end
        checks++;
        if (!round_en && k_addr !== 6'd0) begin
            errors++;
            $display("FAIL kaddr_idle t=%0t got %0d want 0", $time, k_addr);
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({blk_ready, busy, init_iv, load_vars, round_en, k_addr, h_update, digest_valid} !== {2'b10, 3'b000, 6'd0, 2'b00}) begin
            errors++;
            $display("FAIL reset_state got rdy=%b busy=%b rnd=%b k=%0d want rdy=1 busy=0", blk_ready, busy, round_en, k_addr);
        end
        blk_valid = 1'b1; first_blk = 1'b1; last_blk = 1'b1;
        tick();
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL accept_in_reset got busy=%b want 0", busy);
        end
        blk_valid = 1'b0;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_block();
        blk_valid = 1'b1; first_blk = 1'b1; last_blk = 1'b1;
        tick();
        blk_valid = 1'b0;
        checks++;
        if (init_iv !== 1'b1) begin
            errors++;
            $display("FAIL single_init got %b want 1", init_iv);
        end
        for (int i = 0; i < N; i++) begin
            tick();
            checks++;
            if ({round_en, k_addr, w_sched} !== {1'b1, 6'(i), (i >= 16)}) begin
                errors++;
                $display("FAIL single_round i=%0d got en=%b k=%0d w=%b", i, round_en, k_addr, w_sched);
            end
        end
        tick();
        checks++;
        if (h_update !== 1'b1) begin
            errors++;
            $display("FAIL single_update got %b want 1", h_update);
        end
        tick();
        checks++;
        if (digest_valid !== 1'b1) begin
            errors++;
            $display("FAIL single_digest got %b want 1", digest_valid);
        end
    endtask

    task automatic test_digest_handshake();
        digest_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (digest_valid !== 1'b1) begin
                errors++;
                $display("FAIL digest_hold i=%0d got %b want 1", i, digest_valid);
            end
        end
        digest_ready = 1'b1;
        tick();
        digest_ready = 1'b0;
        checks++;
        if ({digest_valid, blk_ready} !== 2'b01) begin
            errors++;
            $display("FAIL digest_release got dv=%b rdy=%b want dv=0 rdy=1", digest_valid, blk_ready);
        end
    endtask

    task automatic test_back_to_back();
        int dv_eps;
        bit seen_upd, prev_dv;
        dv_eps = 0; seen_upd = 0; prev_dv = 0;
        digest_ready = 1'b1;
        blk_valid = 1'b1; first_blk = 1'b1; last_blk = 1'b0;
        tick();
        first_blk = 1'b0; last_blk = 1'b1;
        for (int i = 0; i < 200 && !seen_upd; i++) begin
            tick();
            seen_upd = h_update;
        end
        checks++;
        if (!seen_upd) begin
            errors++;
            $display("FAIL b2b_update got none want h_update within 200 cycles");
        end
        tick();
        checks++;
        if (blk_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready got %b want 1", blk_ready);
        end
        tick();
        blk_valid = 1'b0;
        checks++;
        if ({init_iv, load_vars} !== 2'b01) begin
            errors++;
            $display("FAIL b2b_loadvars got init=%b load=%b want init=0 load=1", init_iv, load_vars);
        end
        for (int i = 0; i < 100; i++) begin
            tick();
            if (digest_valid && !prev_dv) dv_eps++;
            prev_dv = digest_valid;
        end
        digest_ready = 1'b0;
        checks++;
        if (dv_eps != 1) begin
            errors++;
            $display("FAIL b2b_episodes got %0d want 1", dv_eps);
        end
    endtask

    task automatic test_abort();
        int upd, rnds;
        bit hit;
        upd = 0; rnds = 0; hit = 0;
        blk_valid = 1'b1; first_blk = 1'b1; last_blk = 1'b1;
        tick();
        blk_valid = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            tick();
            upd += 32'(h_update);
            hit = round_en && (k_addr == 6'd30);
        end
        abort = 1'b1;
        blk_valid = 1'b1;
        tick();
        abort = 1'b0;
        blk_valid = 1'b0;
        checks++;
        if ({hit, busy, blk_ready, digest_valid} !== 4'b1010 || upd != 0) begin
            errors++;
            $display("FAIL abort_idle got hit=%b busy=%b rdy=%b dv=%b upd=%0d want 1010 upd=0",
                     hit, busy, blk_ready, digest_valid, upd);
        end
        blk_valid = 1'b1; first_blk = 1'b1; last_blk = 1'b0;
        tick();
        blk_valid = 1'b0;
        for (int i = 0; i < 100 && busy; i++) begin
            tick();
            rnds += 32'(round_en);
        end
        checks++;
        if (rnds != N) begin
            errors++;
            $display("FAIL abort_next_rounds got %0d want %0d", rnds, N);
        end
    endtask

    task automatic test_async_reset();
        int upd, rnds;
        upd = 0; rnds = 0;
        blk_valid = 1'b1; first_blk = 1'b1; last_blk = 1'b1;
        tick();
        blk_valid = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({round_en, k_addr, busy, blk_ready, h_update} !== {1'b0, 6'd0, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL async_reset got en=%b k=%0d busy=%b rdy=%b", round_en, k_addr, busy, blk_ready);
        end
        #1 rst = 1'b0;
        tick();
        blk_valid = 1'b1;
        tick();
        blk_valid = 1'b0;
        digest_ready = 1'b1;
        for (int i = 0; i < 100 && busy; i++) begin
            tick();
            rnds += 32'(round_en);
            upd  += 32'(h_update);
        end
        digest_ready = 1'b0;
        checks++;
        if (rnds != N || upd != 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL after_reset_block got rounds=%0d upd=%0d busy=%b want %0d 1 0", rnds, upd, busy, N);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            blk_valid    = ($urandom_range(0, 1) == 1);
            first_blk    = ($urandom_range(0, 1) == 1);
            last_blk     = ($urandom_range(0, 1) == 1);
            abort        = ($urandom_range(0, 59) == 0);
            digest_ready = ($urandom_range(0, 3) == 0);
            tick();
        end
        blk_valid = 1'b0; abort = 1'b0; digest_ready = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_block();
        test_digest_handshake();
        test_back_to_back();
        test_abort();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
